// File: rtl/multicycle_alu.sv
// multicycle_alu: clocked ALU with iterative multiply/divide and start/busy/done handshake
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] r15,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         st;
  logic [CW-1:0]  cnt;
  logic           is_mul;
  logic [WIDTH-1:0] m, hi, lo;
  logic [WIDTH:0]   sum, dif, madd, cmp;
  logic [WIDTH-1:0] diff, nhi, nlo, s_op1, s_r15;
  logic             is_add, is_sub, take, long_op, s_c, s_v, s_dz;

  // single-cycle results from the live operands at the accepting edge
  always_comb begin
    is_add  = control == 4'b0000 || control == 4'b1000;
    is_sub  = control == 4'b0001;
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    long_op = control == 4'b0010 || (control == 4'b0011 && b != '0);
    s_op1   = is_add ? sum[WIDTH-1:0] :
              is_sub ? dif[WIDTH-1:0] :
              control == 4'b0100 ? a & b :
              control == 4'b0111 ? a | b :
              control == 4'b0011 ? '1 : '0;
    s_r15   = control == 4'b0011 ? a : '0;
    s_c     = is_add ? sum[WIDTH] : is_sub ? dif[WIDTH] : 1'b0;
    s_v     = is_add ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
              is_sub ? (a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    s_dz    = control == 4'b0011;
  end

  // one shift-add or restoring-division step on the {hi, lo} pair
  always_comb begin
    madd = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    cmp  = {hi, lo[WIDTH-1]};
    take = cmp >= {1'b0, m};
    diff = cmp[WIDTH-1:0] - m;
    nhi  = is_mul ? madd[WIDTH:1] : (take ? diff : cmp[WIDTH-1:0]);
    nlo  = is_mul ? {madd[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], take};
  end

  // control FSM with registered results and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      is_mul <= 1'b0;
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
      op1    <= '0;
      r15    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      zero   <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == IDLE && start) begin
        busy <= 1'b1;
        m    <= b;
        if (long_op) begin
          hi     <= '0;
          lo     <= a;
          cnt    <= CW'(WIDTH);
          is_mul <= ~control[0];
          st     <= RUN;
        end else begin
          st   <= DONE;
          done <= 1'b1;
          op1  <= s_op1;
          r15  <= s_r15;
          zero <= s_op1 == '0;
          cout <= s_c;
          ovf  <= s_v;
          dz   <= s_dz;
        end
      end else if (st == RUN) begin
        hi  <= nhi;
        lo  <= nlo;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          st   <= DONE;
          done <= 1'b1;
          op1  <= nlo;
          r15  <= nhi;
          zero <= nlo == '0;
          cout <= 1'b0;
          ovf  <= is_mul && nhi != '0;
          dz   <= 1'b0;
        end
      end else if (st == DONE) begin
        st   <= IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: table-driven check of multicycle_alu at WIDTH=16 and WIDTH=8
module tb_multicycle_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, busy, done, zero, cout, ovf, dz;
  logic [3:0]  control;
  logic [15:0] a, b, op1, r15;

  logic       start8, busy8, done8, zero8, cout8, ovf8, dz8;
  logic [3:0] control8;
  logic [7:0] a8, b8, op1_8, r15_8;

  multicycle_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control(control), .a(a), .b(b),
    .op1(op1), .r15(r15), .busy(busy), .done(done),
    .zero(zero), .cout(cout), .ovf(ovf), .dz(dz)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .control(control8), .a(a8), .b(b8),
    .op1(op1_8), .r15(r15_8), .busy(busy8), .done(done8),
    .zero(zero8), .cout(cout8), .ovf(ovf8), .dz(dz8)
  );

  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] a, b, op1, r15;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [3:0] ctl;
    logic [7:0] a, b, op1, r15;
    int         lat;
  } vec8_t;

  int tests = 0;
  int fails = 0;
  vec_t  v[14];
  vec8_t w[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1; control = c; a = x; b = y;
    @(negedge clk);
    start = 1'b0; control = 4'hF; a = 16'hDEAD; b = 16'hBEEF;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input vec_t t, input int i);
    int lat;
    issue(t.ctl, t.a, t.b);
    wait_done(lat);
    chk($sformatf("v%0d_latency", i), lat, t.lat);
    chk($sformatf("v%0d_op1", i), {16'd0, op1}, {16'd0, t.op1});
    chk($sformatf("v%0d_r15", i), {16'd0, r15}, {16'd0, t.r15});
    chk($sformatf("v%0d_flags", i), {28'd0, zero, cout, ovf, dz}, {28'd0, t.flags});
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_busy_clear", i), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, extra;
    //           ctl      a         b         op1       r15       {z,c,v,dz} lat
    v[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 1};
    v[1]  = '{4'b0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b1000, 1};
    v[2]  = '{4'b0010, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010, 17};
    v[3]  = '{4'b0010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 17};
    v[4]  = '{4'b0011, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 17};
    v[5]  = '{4'b0011, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 4'b0001, 1};
    v[6]  = '{4'b1111, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b1000, 1};
    v[7]  = '{4'b0100, 16'h0F0F, 16'h00FF, 16'h000F, 16'h0000, 4'b0000, 1};
    v[8]  = '{4'b0111, 16'hF000, 16'h000F, 16'hF00F, 16'h0000, 4'b0000, 1};
    v[9]  = '{4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0100, 1};
    v[10] = '{4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0010, 1};
    v[11] = '{4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1};
    v[12] = '{4'b0011, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 4'b1000, 17};
    v[13] = '{4'b0010, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 17};
    w[0]  = '{4'b0011, 8'd200, 8'd15, 8'd13,  8'd5,  9};
    w[1]  = '{4'b0010, 8'hFF,  8'h02, 8'hFE,  8'h01, 9};

    rst_n = 1'b0; start = 1'b0; control = 4'h0; a = '0; b = '0;
    start8 = 1'b0; control8 = 4'h0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {op1, r15}, 32'd0);
    chk("reset_status", {26'd0, busy, done, zero, cout, ovf, dz}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(v[i], i);

    // start pulse during a multiply must be ignored
    issue(4'b0010, 16'h1234, 16'h0100);
    lat = 1;
    while (!done && lat < 40) begin
      start = (lat == 5);
      control = 4'b0100;
      @(negedge clk);
      lat++;
      if (lat == 6) chk("busy_mid_mul", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    chk("mid_start_latency", lat, 17);
    chk("mid_start_result", {op1, r15}, 32'h3400_0012);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("mid_start_extra_done", extra, 0);

    // reset in the 5th cycle of a divide discards it
    issue(4'b0011, 16'd100, 16'd7);
    lat = 1;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {op1, r15}, 32'd0);
    chk("rst_mid_status", {26'd0, busy, done, zero, cout, ovf, dz}, 32'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("rst_mid_no_done", extra, 0);
    run_vec('{4'b0000, 16'd2, 16'd3, 16'd5, 16'd0, 4'b0000, 1}, 99);

    // WIDTH=8 instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start8 = 1'b1; control8 = w[i].ctl; a8 = w[i].a; b8 = w[i].b;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
      lat = 1;
      while (!done8 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("w%0d_latency", i), lat, w[i].lat);
      chk($sformatf("w%0d_result", i), {16'd0, op1_8, r15_8}, {16'd0, w[i].op1, w[i].r15});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
